// File: rtl/vend_multi.sv
// Parametrised token vending controller: counts token credit, sells one product per press
// against a price table, hands off to the dispenser and refunds leftover credit.
module vend_multi #(
    parameter int NUM_PRODUCTS = 3,
    parameter int CREDIT_W = 4,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {4'd3, 4'd2, 4'd1},
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int SEL_W = $clog2(NUM_PRODUCTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PRODUCTS-1:0] button,
    input  logic                    token_in,
    input  logic                    cancel,
    input  logic                    dispense_done,
    output logic                    select_valid,
    output logic [SEL_W-1:0]        select_id,
    output logic                    refund_valid,
    output logic [CREDIT_W-1:0]     refund_count,
    output logic                    token_reject,
    output logic                    insufficient,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    busy
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_REFUND} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                select_valid_q, select_valid_d;
    logic [SEL_W-1:0]    select_id_q, select_id_d;
    logic                refund_valid_q, refund_valid_d;
    logic [CREDIT_W-1:0] refund_count_q, refund_count_d;
    logic                token_reject_q, token_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q, busy_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    int                  press_i;
    logic                press_found;
    logic [CREDIT_W-1:0] price;

    always_comb begin
        press_i     = 0;
        press_found = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (button[i] && !press_found) begin
                press_i     = i;
                press_found = 1'b1;
            end
        end
        price = PRICES[press_i*CREDIT_W +: CREDIT_W];
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        select_valid_d = select_valid_q;
        select_id_d    = select_id_q;
        refund_valid_d = 1'b0;
        refund_count_d = '0;
        token_reject_d = 1'b0;
        insufficient_d = 1'b0;
        tmo_d          = '0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                // A press owns the cycle: any token alongside it is turned away.
                if (press_found) begin
                    token_reject_d = token_in;
                    if (credit_q >= price) begin
                        state_d        = S_DISPENSE;
                        select_valid_d = 1'b1;
                        select_id_d    = SEL_W'(press_i);
                        credit_d       = credit_q - price;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (cancel && state_q == S_CREDIT) begin
                    token_reject_d = token_in;
                    state_d        = S_REFUND;
                    refund_valid_d = 1'b1;
                    refund_count_d = credit_q;
                    credit_d       = '0;
                end else if (token_in) begin
                    if (credit_q == CREDIT_MAX) begin
                        token_reject_d = 1'b1;
                    end else begin
                        credit_d = credit_q + 1'b1;
                        state_d  = S_CREDIT;
                    end
                end else if (state_q == S_CREDIT && TIMEOUT_CYCLES > 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d        = S_REFUND;
                        refund_valid_d = 1'b1;
                        refund_count_d = credit_q;
                        credit_d       = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                token_reject_d = token_in;
                if (dispense_done) begin
                    select_valid_d = 1'b0;
                    select_id_d    = '0;
                    if (credit_q != '0) begin
                        state_d        = S_REFUND;
                        refund_valid_d = 1'b1;
                        refund_count_d = credit_q;
                        credit_d       = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                token_reject_d = token_in;
                state_d        = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DISPENSE) || (state_d == S_REFUND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            select_valid_q <= 1'b0;
            select_id_q    <= '0;
            refund_valid_q <= 1'b0;
            refund_count_q <= '0;
            token_reject_q <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            select_valid_q <= select_valid_d;
            select_id_q    <= select_id_d;
            refund_valid_q <= refund_valid_d;
            refund_count_q <= refund_count_d;
            token_reject_q <= token_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
            tmo_q          <= tmo_d;
        end
    end

    assign select_valid = select_valid_q;
    assign select_id    = select_id_q;
    assign refund_valid = refund_valid_q;
    assign refund_count = refund_count_q;
    assign token_reject = token_reject_q;
    assign insufficient = insufficient_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_multi.sv
// Bench for vend_multi: directed scenarios plus randomized traffic checked against a
// transaction-level vending model (credit total, dispensing flag, idle-cycle count).
module tb_vend_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] button;
    logic       token_in, cancel, dispense_done;
    logic       select_valid, refund_valid, token_reject, insufficient, busy;
    logic [1:0] select_id;
    logic [3:0] refund_count, credit;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int   price [3] = '{1, 2, 3};
    int   m_credit, m_sel, m_idle;
    bit   m_disp, m_refund;
    bit   e_rej, e_ins, e_rv;
    int   e_rc;

    vend_multi #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .button(button), .token_in(token_in),
        .cancel(cancel), .dispense_done(dispense_done),
        .select_valid(select_valid), .select_id(select_id),
        .refund_valid(refund_valid), .refund_count(refund_count),
        .token_reject(token_reject), .insufficient(insufficient),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_credit = 0; m_sel = 0; m_idle = 0; m_disp = 0; m_refund = 0;
        e_rej = 0; e_ins = 0; e_rv = 0; e_rc = 0;
    endtask

    task automatic model_refund();
        e_rv = 1; e_rc = m_credit; m_credit = 0; m_refund = 1; m_idle = 0;
    endtask

    // Predicts what the outputs look like after the coming clock edge.
    task automatic model_update(input logic [2:0] b, input bit t, input bit c, input bit d);
        int idx;
        e_rej = 0; e_ins = 0; e_rv = 0; e_rc = 0;
        if (m_disp) begin
            e_rej = t;
            if (d) begin
                m_disp = 0; m_sel = 0;
                if (m_credit > 0) model_refund();
            end
        end else if (m_refund) begin
            e_rej = t; m_refund = 0;
        end else if (b != 0) begin
            idx = 0;
            while (!b[idx]) idx++;
            e_rej = t; m_idle = 0;
            if (m_credit >= price[idx]) begin
                m_credit -= price[idx]; m_disp = 1; m_sel = idx;
            end else e_ins = 1;
        end else if (c && m_credit > 0) begin
            e_rej = t; model_refund();
        end else if (t) begin
            m_idle = 0;
            if (m_credit == 15) e_rej = 1; else m_credit++;
        end else if (m_credit > 0) begin
            m_idle++;
            if (m_idle == 8) model_refund();
        end
    endtask

    task automatic step(input logic [2:0] b, input bit t, input bit c, input bit d);
        button = b; token_in = t; cancel = c; dispense_done = d;
        model_update(b, t, c, d);
        @(posedge clk); #1;
        button = '0; token_in = 0; cancel = 0; dispense_done = 0;
    endtask

    task automatic do_reset();
        reset = 1; button = '0; token_in = 0; cancel = 0; dispense_done = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({select_valid, select_id, refund_valid, refund_count, token_reject,
                         insufficient, credit, busy} !== '0)
            $display("FAIL reset_outputs got sv=%b id=%0d rv=%b rc=%0d rej=%b ins=%b cr=%0d busy=%b exp all 0",
                     select_valid, select_id, refund_valid, refund_count, token_reject, insufficient, credit, busy);
        else n_pass++;
    endtask

    task automatic test_buy_exact();
        step(3'b000, 1, 0, 0);
        n_checks++; if (credit !== 4'd1) $display("FAIL exact_tok1 credit got %0d exp 1", credit); else n_pass++;
        step(3'b000, 1, 0, 0);
        n_checks++; if (credit !== 4'd2) $display("FAIL exact_tok2 credit got %0d exp 2", credit); else n_pass++;
        step(3'b010, 0, 0, 0);
        n_checks++; if ({select_valid, select_id, credit, busy} !== {1'b1, 2'd1, 4'd0, 1'b1})
            $display("FAIL exact_press got sv=%b id=%0d cr=%0d busy=%b exp sv=1 id=1 cr=0 busy=1", select_valid, select_id, credit, busy);
        else n_pass++;
        step(3'b000, 0, 0, 1);
        n_checks++; if ({select_valid, refund_valid, busy} !== 3'b000)
            $display("FAIL exact_done got sv=%b rv=%b busy=%b exp 0 0 0", select_valid, refund_valid, busy);
        else n_pass++;
    endtask

    task automatic test_buy_refund();
        for (int i = 0; i < 5; i++) step(3'b000, 1, 0, 0);
        step(3'b001, 0, 0, 0);
        n_checks++; if ({select_valid, select_id, credit} !== {1'b1, 2'd0, 4'd4})
            $display("FAIL refund_press got sv=%b id=%0d cr=%0d exp sv=1 id=0 cr=4", select_valid, select_id, credit);
        else n_pass++;
        step(3'b000, 0, 0, 1);
        n_checks++; if ({refund_valid, refund_count, credit, select_valid} !== {1'b1, 4'd4, 4'd0, 1'b0})
            $display("FAIL refund_pulse got rv=%b rc=%0d cr=%0d sv=%b exp rv=1 rc=4 cr=0 sv=0", refund_valid, refund_count, credit, select_valid);
        else n_pass++;
        step(3'b000, 0, 0, 0);
        n_checks++; if ({refund_valid, busy, credit} !== {1'b0, 1'b0, 4'd0})
            $display("FAIL refund_idle got rv=%b busy=%b cr=%0d exp 0 0 0", refund_valid, busy, credit);
        else n_pass++;
    endtask

    task automatic test_insufficient();
        step(3'b000, 1, 0, 0);
        step(3'b100, 0, 0, 0);
        n_checks++; if ({insufficient, credit, select_valid} !== {1'b1, 4'd1, 1'b0})
            $display("FAIL insuff_press got ins=%b cr=%0d sv=%b exp ins=1 cr=1 sv=0", insufficient, credit, select_valid);
        else n_pass++;
        step(3'b000, 0, 1, 0);
        n_checks++; if ({refund_valid, refund_count, insufficient} !== {1'b1, 4'd1, 1'b0})
            $display("FAIL insuff_cancel got rv=%b rc=%0d ins=%b exp rv=1 rc=1 ins=0", refund_valid, refund_count, insufficient);
        else n_pass++;
        step(3'b000, 0, 0, 0);
        step(3'b001, 0, 0, 0);
        n_checks++; if ({insufficient, select_valid} !== 2'b10)
            $display("FAIL insuff_idle got ins=%b sv=%b exp ins=1 sv=0", insufficient, select_valid);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 16; i++) begin
            step(3'b000, 1, 0, 0);
            n_checks++;
            if (credit !== 4'((i > 15) ? 15 : i) || token_reject !== (i == 16))
                $display("FAIL sat_tok%0d got cr=%0d rej=%b exp cr=%0d rej=%b", i, credit, token_reject, (i > 15) ? 15 : i, i == 16);
            else n_pass++;
        end
        step(3'b100, 0, 0, 0);
        step(3'b000, 1, 0, 0);
        n_checks++; if ({token_reject, credit, select_valid} !== {1'b1, 4'd12, 1'b1})
            $display("FAIL disp_token got rej=%b cr=%0d sv=%b exp rej=1 cr=12 sv=1", token_reject, credit, select_valid);
        else n_pass++;
        step(3'b000, 0, 0, 1);
        n_checks++; if ({refund_valid, refund_count} !== {1'b1, 4'd12})
            $display("FAIL disp_refund got rv=%b rc=%0d exp rv=1 rc=12", refund_valid, refund_count);
        else n_pass++;
        step(3'b000, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) step(3'b000, 1, 0, 0);
        step(3'b110, 1, 0, 0);
        n_checks++; if ({select_valid, select_id, token_reject, credit} !== {1'b1, 2'd1, 1'b1, 4'd1})
            $display("FAIL simul got sv=%b id=%0d rej=%b cr=%0d exp sv=1 id=1 rej=1 cr=1", select_valid, select_id, token_reject, credit);
        else n_pass++;
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int waited;
        bit seen;
        step(3'b000, 1, 0, 0);
        waited = 0; seen = 0;
        while (!seen && waited < 20) begin
            step(3'b000, 0, 0, 0);
            waited++;
            if (refund_valid) seen = 1;
        end
        n_checks++; if (!seen || waited != 8 || refund_count !== 4'd1)
            $display("FAIL timeout got seen=%b cycles=%0d rc=%0d exp seen=1 cycles=8 rc=1", seen, waited, refund_count);
        else n_pass++;
        step(3'b000, 0, 0, 0);
    endtask

    task automatic test_reset_dispense();
        for (int i = 0; i < 3; i++) step(3'b000, 1, 0, 0);
        step(3'b001, 0, 0, 0);
        n_checks++; if ({select_valid, credit} !== {1'b1, 4'd2})
            $display("FAIL rstdisp_setup got sv=%b cr=%0d exp sv=1 cr=2", select_valid, credit);
        else n_pass++;
        reset = 1;
        @(posedge clk); #1;
        n_checks++; if ({select_valid, select_id, refund_valid, refund_count, token_reject,
                         insufficient, credit, busy} !== '0)
            $display("FAIL rstdisp_outputs got sv=%b rv=%b cr=%0d busy=%b exp all 0", select_valid, refund_valid, credit, busy);
        else n_pass++;
        reset = 0;
        model_reset();
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 0);
        n_checks++; if ({refund_valid, busy, credit} !== 6'd0)
            $display("FAIL rstdisp_after got rv=%b busy=%b cr=%0d exp 0 0 0", refund_valid, busy, credit);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] b;
        bit t, c, d;
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            b = '0; t = 0; c = 0; d = 0;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: t = 1;
                4:          b = 3'($urandom_range(1, 7));
                5:          begin b = 3'($urandom_range(1, 7)); t = 1; end
                6:          c = 1;
                7, 8:       d = 1;
                default:    ;
            endcase
            step(b, t, c, d);
            n_checks++;
            if (credit !== 4'(m_credit) || select_valid !== m_disp || (m_disp && select_id !== 2'(m_sel))
                || refund_valid !== e_rv || (e_rv && refund_count !== 4'(e_rc))
                || token_reject !== e_rej || insufficient !== e_ins || busy !== (m_disp || m_refund)) begin
                if (bad < 10)
                    $display("FAIL random_cycle%0d got cr=%0d sv=%b id=%0d rv=%b rc=%0d rej=%b ins=%b busy=%b exp cr=%0d sv=%b id=%0d rv=%b rc=%0d rej=%b ins=%b busy=%b",
                             n, credit, select_valid, select_id, refund_valid, refund_count, token_reject, insufficient, busy,
                             m_credit, m_disp, m_sel, e_rv, e_rc, e_rej, e_ins, m_disp || m_refund);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_buy_exact();
        test_buy_refund();
        test_insufficient();
        test_saturate();
        test_simultaneous();
        test_timeout();
        test_reset_dispense();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
